// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch control stage. Walks FETCH -> WAIT -> DECODE for every
//   instruction. It reads the synchronous program memory at the program
//   counter address and latches the word. It then resolves NOP, JMP and HLT
//   locally and hands every other opcode to the execute stage through the
//   instrValid / execDone handshake.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   run         start request (sampled in IDLE and HALT only)
//   pcAdr       current program counter value
//   memData     program memory read data (valid in the cycle after memRe)
//   execDone    execute stage has finished the presented instruction
//   memAdr      program memory address (follows pcAdr)
//   memRe       program memory read strobe
//   rstPC       program counter reset strobe
//   cePC        program counter increment strobe
//   wrJumpAdr   program counter jump-load strobe
//   jumpAdr     jump target taken from the low bits of instr
//   instr       latched instruction word
//   instrValid  instr is presented to the execute stage
//   halted      sequencer is parked in HALT
module fetch_sequencer #(
    parameter int prog_mem_length = 8,
    parameter int instr_width     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic [prog_mem_length-1:0] pcAdr,
    input  logic [instr_width-1:0]     memData,
    input  logic                       execDone,
    output logic [prog_mem_length-1:0] memAdr,
    output logic                       memRe,
    output logic                       rstPC,
    output logic                       cePC,
    output logic                       wrJumpAdr,
    output logic [prog_mem_length-1:0] jumpAdr,
    output logic [instr_width-1:0]     instr,
    output logic                       instrValid,
    output logic                       halted
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state;
    logic [3:0] opcode;

    assign opcode  = instr[instr_width-1 -: 4];
    assign memAdr  = pcAdr;
    assign jumpAdr = instr[prog_mem_length-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            instr <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (run) state <= ST_FETCH;
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    instr <= memData;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_NOP:  state <= ST_FETCH;
                        OP_JMP:  state <= ST_FETCH;
                        OP_HLT:  state <= ST_HALT;
                        default: state <= ST_EXEC;
                    endcase
                end
                ST_EXEC:  if (execDone) state <= ST_FETCH;
                ST_HALT:  if (!run) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are decoded from state rather than registered: cePC has to fire
    // in the same cycle as execDone, and the DECODE strobes depend on the
    // opcode that was latched one edge earlier.
    always_comb begin
        memRe      = 1'b0;
        rstPC      = 1'b0;
        cePC       = 1'b0;
        wrJumpAdr  = 1'b0;
        instrValid = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_IDLE:  rstPC = 1'b1;
            ST_FETCH: memRe = 1'b1;
            ST_DECODE: begin
                cePC      = (opcode == OP_NOP);
                wrJumpAdr = (opcode == OP_JMP);
            end
            ST_EXEC: begin
                instrValid = 1'b1;
                cePC       = execDone;
            end
            ST_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Bench for fetch_sequencer. A behavioural program counter and a 256-word
//   synchronous program memory close the loop around the DUT. Each scenario
//   pushes the fetch addresses it expects into a queue. A monitor pops the
//   queue whenever the DUT raises memRe and compares the popped address.
module tb_fetch_sequencer;

    localparam int PML = 8;
    localparam int IW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic [PML-1:0] pcAdr;
    logic [IW-1:0]  memData;
    logic           execDone;
    logic [PML-1:0] memAdr;
    logic           memRe;
    logic           rstPC;
    logic           cePC;
    logic           wrJumpAdr;
    logic [PML-1:0] jumpAdr;
    logic [IW-1:0]  instr;
    logic           instrValid;
    logic           halted;

    logic [IW-1:0]  mem [0:255];
    logic [PML-1:0] exp_fetch [$];
    int             checks = 0;
    int             fails  = 0;

    fetch_sequencer #(.prog_mem_length(PML), .instr_width(IW)) dut (
        .clk(clk), .rst(rst), .run(run), .pcAdr(pcAdr), .memData(memData),
        .execDone(execDone), .memAdr(memAdr), .memRe(memRe), .rstPC(rstPC),
        .cePC(cePC), .wrJumpAdr(wrJumpAdr), .jumpAdr(jumpAdr), .instr(instr),
        .instrValid(instrValid), .halted(halted)
    );

    always #5 clk = ~clk;

    // Program counter model: reset beats jump-load, which beats increment.
    always_ff @(posedge clk) begin
        if (rstPC)          pcAdr <= '0;
        else if (wrJumpAdr) pcAdr <= jumpAdr;
        else if (cePC)      pcAdr <= pcAdr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (memRe) memData <= mem[memAdr];
    end

    // Fetch scoreboard and strobe-exclusivity monitor.
    always @(negedge clk) begin
        if (memRe) begin
            checks++;
            if (exp_fetch.size() == 0) begin
                fails++;
                $display("FAIL fetch_unexpected: got addr %0h, expected no fetch", memAdr);
            end else begin
                logic [PML-1:0] e;
                e = exp_fetch.pop_front();
                if (memAdr !== e) begin
                    fails++;
                    $display("FAIL fetch_addr: got %0h, expected %0h", memAdr, e);
                end
            end
        end
        if (cePC || wrJumpAdr) begin
            checks++;
            if (cePC && wrJumpAdr) begin
                fails++;
                $display("FAIL strobe_excl: cePC=%b wrJumpAdr=%b, expected not both", cePC, wrJumpAdr);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int unsigned i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic wait_halt(input int budget, input string name);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!halted) begin
            fails++;
            $display("FAIL %s_timeout: halted=%b after %0d cycles, expected 1", name, halted, n);
        end
    endtask

    task automatic to_idle();
        run = 1'b0;
        step();
        step();
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_fetch.size() != 0) begin
            fails++;
            $display("FAIL %s_pending: %0d fetches outstanding, expected 0", name, exp_fetch.size());
            exp_fetch.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({rstPC, memRe, cePC, wrJumpAdr, instrValid, halted} !== 6'b100000) begin
            fails++;
            $display("FAIL %s_strobes: rstPC/memRe/cePC/wrJ/valid/halted=%b, expected 100000", name,
                     {rstPC, memRe, cePC, wrJumpAdr, instrValid, halted});
        end
        checks++;
        if (instr !== 16'h0000 || jumpAdr !== 8'h00) begin
            fails++;
            $display("FAIL %s_instr: instr=%h jumpAdr=%h, expected 0000/00", name, instr, jumpAdr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; execDone = 1'b0;
        clear_mem();
        step(); step();
        rst = 1'b0;
        check_idle_outputs("reset");
        step();
        checks++;
        if (pcAdr !== 8'h00) begin
            fails++;
            $display("FAIL reset_pc: got %h, expected 00", pcAdr);
        end
    endtask

    task automatic test_nop_halt();
        int ce, hc;
        clear_mem();
        mem[2] = 16'hF000;
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01); exp_fetch.push_back(8'h02);
        ce = 0; hc = 0;
        run = 1'b1;
        for (int n = 1; n <= 20 && hc == 0; n++) begin
            step();
            if (cePC) ce++;
            if (halted) hc = n;
        end
        checks++;
        if (hc != 10) begin
            fails++;
            $display("FAIL nop_halt_cycle: got %0d, expected 10", hc);
        end
        checks++;
        if (ce != 2) begin
            fails++;
            $display("FAIL nop_ce_count: got %0d, expected 2", ce);
        end
        checks++;
        if (pcAdr !== 8'h02) begin
            fails++;
            $display("FAIL nop_pc: got %h, expected 02", pcAdr);
        end
        check_queue_empty("nop");
        to_idle();
    endtask

    task automatic test_jump();
        int wj, ce, n;
        logic [PML-1:0] tgt;
        clear_mem();
        mem[0] = 16'hE005;
        mem[5] = 16'hF000;
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h05);
        wj = 0; ce = 0; n = 0; tgt = '0;
        run = 1'b1;
        while (!halted && n < 30) begin
            step();
            n++;
            if (wrJumpAdr) begin wj++; tgt = jumpAdr; end
            if (cePC) ce++;
        end
        checks++;
        if (wj != 1 || tgt !== 8'h05) begin
            fails++;
            $display("FAIL jump_strobe: pulses=%0d target=%h, expected 1/05", wj, tgt);
        end
        checks++;
        if (ce != 0) begin
            fails++;
            $display("FAIL jump_ce: got %0d cePC pulses, expected 0", ce);
        end
        wait_halt(5, "jump");
        checks++;
        if (pcAdr !== 8'h05) begin
            fails++;
            $display("FAIL jump_pc: got %h, expected 05", pcAdr);
        end
        check_queue_empty("jump");
        to_idle();
    endtask

    task automatic test_exec();
        int v, ce, n;
        clear_mem();
        mem[0] = 16'h3ABC;
        mem[1] = 16'hF000;
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
        v = 0; ce = 0; n = 0;
        execDone = 1'b0;
        run = 1'b1;
        while (!halted && n < 40) begin
            step();
            n++;
            execDone = 1'b0;
            if (cePC) ce++;
            if (instrValid) begin
                v++;
                checks++;
                if (instr !== 16'h3ABC) begin
                    fails++;
                    $display("FAIL exec_instr: got %h, expected 3abc", instr);
                end
                if (v == 5) begin
                    execDone = 1'b1;
                    #1;
                    checks++;
                    if (cePC !== 1'b1) begin
                        fails++;
                        $display("FAIL exec_done_ce: got %b, expected 1", cePC);
                    end
                    if (cePC) ce++;
                end
            end
        end
        execDone = 1'b0;
        checks++;
        if (v != 5) begin
            fails++;
            $display("FAIL exec_valid_len: got %0d, expected 5", v);
        end
        checks++;
        if (ce != 1) begin
            fails++;
            $display("FAIL exec_ce_count: got %0d, expected 1", ce);
        end
        wait_halt(5, "exec");
        check_queue_empty("exec");
        to_idle();
    endtask

    task automatic test_wrap();
        int n;
        logic ce_at_ff;
        clear_mem();
        mem[0] = 16'hE0FF;
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'hFF); exp_fetch.push_back(8'h00);
        n = 0; ce_at_ff = 1'b0;
        run = 1'b1;
        while (!halted && n < 30) begin
            step();
            n++;
            // Once the jump has been taken, replace word 0 so the wrap lands on a halt.
            if (wrJumpAdr) mem[0] = 16'hF000;
            if (cePC && pcAdr == 8'hFF) ce_at_ff = 1'b1;
        end
        checks++;
        if (!ce_at_ff) begin
            fails++;
            $display("FAIL wrap_ce: got no cePC at pc ff, expected one");
        end
        wait_halt(5, "wrap");
        checks++;
        if (pcAdr !== 8'h00) begin
            fails++;
            $display("FAIL wrap_pc: got %h, expected 00", pcAdr);
        end
        check_queue_empty("wrap");
        to_idle();
    endtask

    task automatic test_reset_mid();
        int n;
        clear_mem();
        mem[0] = 16'h3ABC;
        exp_fetch.push_back(8'h00);
        run = 1'b1; n = 0;
        while (!instrValid && n < 20) begin step(); n++; end
        rst = 1'b1; run = 1'b0;
        step();
        rst = 1'b0;
        check_idle_outputs("rst_exec");
        execDone = 1'b1;
        #1;
        checks++;
        if (cePC !== 1'b0 || wrJumpAdr !== 1'b0 || memRe !== 1'b0) begin
            fails++;
            $display("FAIL idle_execdone: cePC/wrJ/memRe=%b%b%b, expected 000", cePC, wrJumpAdr, memRe);
        end
        step();
        execDone = 1'b0;
        checks++;
        if (rstPC !== 1'b1) begin
            fails++;
            $display("FAIL idle_hold: rstPC=%b, expected 1", rstPC);
        end
        exp_fetch.push_back(8'h00);
        run = 1'b1; n = 0;
        while (!memRe && n < 20) begin step(); n++; end
        step();
        rst = 1'b1; run = 1'b0;
        step();
        rst = 1'b0;
        check_idle_outputs("rst_wait");
        check_queue_empty("reset_mid");
        step();
    endtask

    task automatic test_halt_restart();
        clear_mem();
        mem[0] = 16'hF000;
        exp_fetch.push_back(8'h00);
        run = 1'b1;
        wait_halt(20, "restart1");
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (halted !== 1'b1 || rstPC !== 1'b0) begin
                fails++;
                $display("FAIL halt_hold: halted=%b rstPC=%b, expected 1/0", halted, rstPC);
            end
        end
        run = 1'b0;
        step();
        checks++;
        if (halted !== 1'b0 || rstPC !== 1'b1) begin
            fails++;
            $display("FAIL halt_release: halted=%b rstPC=%b, expected 0/1", halted, rstPC);
        end
        exp_fetch.push_back(8'h00);
        run = 1'b1;
        wait_halt(20, "restart2");
        check_queue_empty("restart");
        to_idle();
    endtask

    initial begin
        test_reset();
        test_nop_halt();
        test_jump();
        test_exec();
        test_wrap();
        test_reset_mid();
        test_halt_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
